rng_scheduler: RTL and testbench

Shares one 16-bit pseudo-random source between up to N_REQ requesters in the maze/Q-learning datapath: exploration decision, random action pick, start-cell pick, and so on. It owns the generator, sequences seeding and warm-up, and grants one 8-bit random value per request over a req/ack handshake with round-robin fairness. The output is deterministic for a given seed and request order, so a bench can predict it exactly.

---
 rtl/rng_pkg.sv | 24 ++
 rtl/rng_lfsr16.sv | 40 ++++
 rtl/rng_scheduler.sv | 143 ++++++++++++++
 tb/tb_rng_scheduler.sv | 211 +++++++++++++++++++++
 4 files changed

// File: rtl/rng_pkg.sv
// Shared types and constants for the random-number scheduler: FSM states,
// generator geometry, default seed and the LFSR feedback function.
package rng_pkg;

    typedef enum logic {
        WARM  = 1'b0,
        SERVE = 1'b1
    } state_e;

    localparam int LFSR_W = 16;
    localparam int OUT_W  = 8;
    localparam logic [LFSR_W-1:0] DEFAULT_SEED = 16'hACE1;

    localparam int TAP0 = 0;
    localparam int TAP1 = 2;
    localparam int TAP2 = 3;
    localparam int TAP3 = 5;

    // x^16+x^14+x^13+x^11+1 in right-shifting Fibonacci form.
    function automatic logic [LFSR_W-1:0] lfsr_next(input logic [LFSR_W-1:0] l);
        return {l[TAP0] ^ l[TAP1] ^ l[TAP2] ^ l[TAP3], l[LFSR_W-1:1]};
    endfunction

endpackage

// File: rtl/rng_lfsr16.sv
// 16-bit Fibonacci LFSR with synchronous load (priority) and step enable;
// asynchronous reset returns it to the configured seed.
module rng_lfsr16
    import rng_pkg::*;
#(
    parameter logic [LFSR_W-1:0] SEED = DEFAULT_SEED
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              load,
    input  logic [LFSR_W-1:0] load_val,
    input  logic              step,
    output logic [LFSR_W-1:0] q
);

    logic [LFSR_W-1:0] q_q;
    logic [LFSR_W-1:0] q_d;

    always_comb begin
        q_d = q_q;
        if (load) begin
            q_d = load_val;
        end else if (step) begin
            q_d = lfsr_next(q_q);
        end else begin
            q_d = q_q;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            q_q <= SEED;
        end else begin
            q_q <= q_d;
        end
    end

    assign q = q_q;

endmodule

// File: rtl/rng_scheduler.sv
// Owns the shared LFSR, sequences seeding/warm-up, and hands out one 8-bit
// random value per request with round-robin fairness over a req/ack handshake.
module rng_scheduler
    import rng_pkg::*;
#(
    parameter int                N_REQ  = 4,
    parameter logic [LFSR_W-1:0] SEED   = DEFAULT_SEED,
    parameter int                WARMUP = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              seed_load,
    input  logic [LFSR_W-1:0] seed,
    input  logic [N_REQ-1:0]  req,
    output logic [N_REQ-1:0]  ack,
    output logic [OUT_W-1:0]  rnd,
    output logic              ready
);

    localparam int PTR_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;
    localparam logic [7:0]       WARMUP_C = 8'(WARMUP);
    localparam logic [N_REQ-1:0] ONE_HOT0 = N_REQ'(1);

    state_e             state_q, state_d;
    logic [7:0]         cnt_q, cnt_d;
    logic [PTR_W-1:0]   ptr_q, ptr_d;
    logic [N_REQ-1:0]   ack_q, ack_d;
    logic [OUT_W-1:0]   rnd_q, rnd_d;

    logic               lfsr_load;
    logic               lfsr_step;
    logic [LFSR_W-1:0]  lfsr_load_val;
    logic [LFSR_W-1:0]  lfsr_q;

    logic               gnt_found;
    logic [PTR_W-1:0]   gnt_idx;
    int unsigned        idx_v;
    int unsigned        nxt_v;

    rng_lfsr16 #(.SEED(SEED)) u_lfsr (
        .clk      (clk),
        .rst      (rst),
        .load     (lfsr_load),
        .load_val (lfsr_load_val),
        .step     (lfsr_step),
        .q        (lfsr_q)
    );

    // Round-robin search: first set request at or above ptr, wrapping.
    always_comb begin
        gnt_found = 1'b0;
        gnt_idx   = '0;
        idx_v     = 0;
        for (int k = 0; k < N_REQ; k++) begin
            idx_v = int'(ptr_q) + k;
            if (idx_v >= N_REQ) begin
                idx_v = idx_v - N_REQ;
            end else begin
                idx_v = idx_v;
            end
            if (!gnt_found && req[idx_v]) begin
                gnt_found = 1'b1;
                gnt_idx   = PTR_W'(idx_v);
            end else begin
                gnt_found = gnt_found;
            end
        end
        nxt_v = int'(gnt_idx) + 1;
        if (nxt_v >= N_REQ) begin
            nxt_v = 0;
        end else begin
            nxt_v = nxt_v;
        end
    end

    // Next-state, generator control and registered grant outputs.
    always_comb begin
        state_d       = state_q;
        cnt_d         = cnt_q;
        ptr_d         = ptr_q;
        ack_d         = '0;
        rnd_d         = rnd_q;
        lfsr_load     = 1'b0;
        lfsr_step     = 1'b0;
        lfsr_load_val = (seed == 16'h0000) ? SEED : seed;

        if (seed_load) begin
            state_d   = WARM;
            cnt_d     = 8'd0;
            ptr_d     = '0;
            lfsr_load = 1'b1;
        end else if (lfsr_q == 16'h0000) begin
            // Lock-up recovery: an all-zero register would never leave zero.
            lfsr_load     = 1'b1;
            lfsr_load_val = SEED;
        end else begin
            case (state_q)
                WARM: begin
                    if (cnt_q == WARMUP_C) begin
                        state_d = SERVE;
                    end else begin
                        lfsr_step = 1'b1;
                        cnt_d     = cnt_q + 8'd1;
                    end
                end
                SERVE: begin
                    if (gnt_found) begin
                        ack_d     = ONE_HOT0 << gnt_idx;
                        rnd_d     = lfsr_q[OUT_W-1:0];
                        lfsr_step = 1'b1;
                        ptr_d     = PTR_W'(nxt_v);
                    end else begin
                        ack_d = '0;
                    end
                end
                default: begin
                    state_d = WARM;
                end
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= WARM;
            cnt_q   <= 8'd0;
            ptr_q   <= '0;
            ack_q   <= '0;
            rnd_q   <= 8'h00;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            ptr_q   <= ptr_d;
            ack_q   <= ack_d;
            rnd_q   <= rnd_d;
        end
    end

    assign ack   = ack_q;
    assign rnd   = rnd_q;
    assign ready = (state_q == SERVE);

endmodule

// File: tb/tb_rng_scheduler.sv
// Scoreboard bench for rng_scheduler: directed stimulus pushes expected grants,
// per-DUT monitors pop and compare whenever an ack appears.
module tb_rng_scheduler;

    typedef struct packed {
        logic [3:0] ack;
        logic [7:0] rnd;
    } exp_t;

    logic        clk;
    logic        rst;
    logic        seed_load, seed_load0;
    logic [15:0] seed, seed0;
    logic [3:0]  req, req0;
    logic [3:0]  ack, ack0;
    logic [7:0]  rnd, rnd0;
    logic        ready, ready0;

    exp_t q_main[$];
    exp_t q_w0[$];
    int   n_vec = 0;
    int   n_err = 0;

    rng_scheduler #(.N_REQ(4), .SEED(16'hACE1), .WARMUP(2)) u_dut (
        .clk(clk), .rst(rst), .seed_load(seed_load), .seed(seed),
        .req(req), .ack(ack), .rnd(rnd), .ready(ready)
    );

    rng_scheduler #(.N_REQ(4), .SEED(16'hACE1), .WARMUP(0)) u_dut0 (
        .clk(clk), .rst(rst), .seed_load(seed_load0), .seed(seed0),
        .req(req0), .ack(ack0), .rnd(rnd0), .ready(ready0)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    function automatic logic [15:0] model_step(input logic [15:0] l);
        logic s;
        s = l[0] ^ l[2] ^ l[3] ^ l[5];
        return {s, l[15:1]};
    endfunction

    task automatic check(input string name, input logic [15:0] got, input logic [15:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", name, got, exp);
        end
    endtask

    // Monitor for the WARMUP=2 instance.
    always @(negedge clk) begin
        exp_t e;
        if (ack !== 4'b0000) begin
            n_vec++;
            if (q_main.size() == 0) begin
                n_err++;
                $display("FAIL main_unexpected_ack: got ack=%b rnd=%h expected no grant", ack, rnd);
            end else begin
                e = q_main.pop_front();
                if (ack !== e.ack || rnd !== e.rnd) begin
                    n_err++;
                    $display("FAIL main_grant: got ack=%b rnd=%h expected ack=%b rnd=%h",
                             ack, rnd, e.ack, e.rnd);
                end
            end
        end
    end

    // Monitor for the WARMUP=0 instance.
    always @(negedge clk) begin
        exp_t e;
        if (ack0 !== 4'b0000) begin
            n_vec++;
            if (q_w0.size() == 0) begin
                n_err++;
                $display("FAIL w0_unexpected_ack: got ack=%b rnd=%h expected no grant", ack0, rnd0);
            end else begin
                e = q_w0.pop_front();
                if (ack0 !== e.ack || rnd0 !== e.rnd) begin
                    n_err++;
                    $display("FAIL w0_grant: got ack=%b rnd=%h expected ack=%b rnd=%h",
                             ack0, rnd0, e.ack, e.rnd);
                end
            end
        end
    end

    // Release reset with req=0001 held: ACE1 -> 5670 -> AB38, grants 38 then 9C.
    task automatic run_first();
        @(negedge clk);
        rst = 1'b0;
        req = 4'b0001;
        q_main.push_back('{ack: 4'b0001, rnd: 8'h38});
        q_main.push_back('{ack: 4'b0001, rnd: 8'h9C});
        @(negedge clk);
        check("ready_after_edge1", {15'd0, ready}, 16'd0);
        check("w0_ready_after_edge1", {15'd0, ready0}, 16'd1);
        @(negedge clk);
        check("ready_after_edge2", {15'd0, ready}, 16'd0);
        @(negedge clk);
        check("ready_after_edge3", {15'd0, ready}, 16'd1);
        @(negedge clk);
        @(negedge clk);
        req = 4'b0000;
    endtask

    initial begin
        logic [15:0] m;
        rst = 1'b0; seed_load = 1'b0; seed = 16'h0000; req = 4'b0000;
        seed_load0 = 1'b0; seed0 = 16'h0000; req0 = 4'b0000;
        #1 rst = 1'b1;
        #1;
        check("reset_ack", {12'd0, ack}, 16'd0);
        check("reset_rnd", {8'd0, rnd}, 16'd0);
        check("reset_ready", {15'd0, ready}, 16'd0);
        check("reset_w0_ready", {15'd0, ready0}, 16'd0);

        run_first();

        // WARMUP=0 instance: nonzero seed served at once, then zero seed -> ACE1.
        @(negedge clk);
        seed_load0 = 1'b1; seed0 = 16'h1234; req0 = 4'b0001;
        q_w0.push_back('{ack: 4'b0001, rnd: 8'h34});
        @(negedge clk);
        seed_load0 = 1'b0;
        check("w0_ready_drop", {15'd0, ready0}, 16'd0);
        check("w0_no_ack_on_load", {12'd0, ack0}, 16'd0);
        @(negedge clk);
        check("w0_ready_back", {15'd0, ready0}, 16'd1);
        @(negedge clk);
        seed_load0 = 1'b1; seed0 = 16'h0000;
        q_w0.push_back('{ack: 4'b0001, rnd: 8'hE1});
        @(negedge clk);
        seed_load0 = 1'b0;
        check("w0_zero_seed_ready_drop", {15'd0, ready0}, 16'd0);
        @(negedge clk);
        check("w0_zero_seed_ready_one_cycle", {15'd0, ready0}, 16'd1);
        @(negedge clk);
        req0 = 4'b0000;

        // seed_load together with a pending req: no ack, grant after warm-up from 1234.
        @(negedge clk);
        seed_load = 1'b1; seed = 16'h1234; req = 4'b0010;
        @(negedge clk);
        seed_load = 1'b0;
        check("seedload_no_ack", {12'd0, ack}, 16'd0);
        check("seedload_ready_drop", {15'd0, ready}, 16'd0);
        q_main.push_back('{ack: 4'b0010, rnd: 8'h8D});
        @(negedge clk);
        @(negedge clk);
        check("seedload_ready_still_low", {15'd0, ready}, 16'd0);
        @(negedge clk);
        check("seedload_ready_rise", {15'd0, ready}, 16'd1);
        @(negedge clk);
        req = 4'b0000;

        // Zero seed (-> ACE1), all four requesting from WARM: strict rotation.
        @(negedge clk);
        seed_load = 1'b1; seed = 16'h0000;
        @(negedge clk);
        seed_load = 1'b0;
        req = 4'b1111;
        q_main.push_back('{ack: 4'b0001, rnd: 8'h38});
        q_main.push_back('{ack: 4'b0010, rnd: 8'h9C});
        q_main.push_back('{ack: 4'b0100, rnd: 8'hCE});
        q_main.push_back('{ack: 4'b1000, rnd: 8'h67});
        q_main.push_back('{ack: 4'b0001, rnd: 8'hB3});
        repeat (3) @(negedge clk);
        check("rr_ready", {15'd0, ready}, 16'd1);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check("rr_grant_every_cycle", {15'd0, (ack != 4'b0000)}, 16'd1);
        end

        // One more grant, then asynchronous reset between edges while ack is high.
        req = 4'b0001;
        @(posedge clk);
        #1;
        check("pre_reset_ack", {12'd0, ack}, 16'h0001);
        check("pre_reset_rnd", {8'd0, rnd}, 16'h0059);
        #1 rst = 1'b1;
        #1;
        check("async_reset_ack", {12'd0, ack}, 16'd0);
        check("async_reset_ready", {15'd0, ready}, 16'd0);
        check("async_reset_rnd", {8'd0, rnd}, 16'd0);

        run_first();

        // Full period from L=2ACE: stream must follow the polynomial and wrap after 65535.
        m = 16'h2ACE;
        for (int i = 0; i < 65536; i++) begin
            q_main.push_back('{ack: 4'b0001, rnd: m[7:0]});
            m = model_step(m);
        end
        @(negedge clk);
        req = 4'b0001;
        repeat (65536) @(negedge clk);
        req = 4'b0000;
        repeat (3) @(negedge clk);

        check("main_queue_drained", 16'(q_main.size()), 16'd0);
        check("w0_queue_drained", 16'(q_w0.size()), 16'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
